rgb_hue_sequencer: RTL and testbench
====================================

RGB_HUE_SEQUENCER -- requirements
Module: rgb_hue_sequencer

Interface
REQ-001 SHALL have parameter TICK_INTERVAL, default 12000, meaning clk cycles per step tick (1 ms at 12 MHz).
REQ-002 SHALL have parameter STEPS_PER_SECTOR, default 200, meaning step ticks per hue sector.
REQ-003 SHALL have parameter PWM_INTERVAL, default 1200, meaning PWM period in clk cycles and full-scale duty value.
REQ-004 SHALL have parameter STEP_VAL, default PWM_INTERVAL / STEPS_PER_SECTOR, meaning duty change per step tick.
REQ-005 SHALL have port clk, input, 1 bit, meaning the single clock for all logic.
REQ-006 SHALL have port rst, input, 1 bit, meaning reset, synchronous and active-high.
REQ-007 SHALL have port enable, input, 1 bit, meaning run when high and freeze sequencing when low.
REQ-008 SHALL have ports duty_r, duty_g, duty_b, output, $clog2(PWM_INTERVAL+1) bits each, meaning current committed duty per channel.
REQ-009 SHALL have ports led_r, led_g, led_b, output, 1 bit each, meaning PWM pin drive, active-high.
REQ-010 SHALL have port sector, output, 3 bits, meaning current hue sector 0..5.
REQ-011 SHALL have port sector_done, output, 1 bit, meaning a one-cycle pulse on each sector transition.

Function
REQ-012 SHALL run all registers on posedge clk only, using tick enables and no derived clocks.
REQ-013 SHALL count with a tick counter 0..TICK_INTERVAL-1 while enable=1, wrap to 0, and assert an internal step tick for one cycle at wrap.
REQ-014 SHALL hold the tick counter, step counter, sector and target duties unchanged while enable=0, and resume from the held count when enable returns to 1.
REQ-015 SHALL use six sector states and on each step tick apply the sector action: S0 G+=STEP_VAL; S1 R-=; S2 B+=; S3 G-=; S4 R+=; S5 B-=.
REQ-016 SHALL saturate incremented duties at PWM_INTERVAL and decremented duties at 0, with no wrap-around.
REQ-017 SHALL count step ticks 0..STEPS_PER_SECTOR-1 per sector; on the tick where the count equals STEPS_PER_SECTOR-1 it SHALL apply that step, advance sector (S5 wraps to S0), clear the count, and pulse sector_done in the following cycle.
REQ-018 SHALL, at every sector transition, force the channel just ramped to its exact endpoint (PWM_INTERVAL or 0) to remove rounding error when STEPS_PER_SECTOR does not divide PWM_INTERVAL.
REQ-019 SHALL run a free-running PWM counter 0..PWM_INTERVAL-1 that is independent of enable.
REQ-020 SHALL copy target duties to duty_r/g/b only in the cycle where the PWM counter is 0, so each period uses one consistent duty.
REQ-021 SHALL drive led_x high iff PWM counter < duty_x, so duty 0 gives a constant low and duty PWM_INTERVAL gives a constant high.
REQ-022 SHALL apply the step first and then the transition when a step tick and a sector end coincide, with one update per cycle.

Reset
REQ-023 SHALL on rst=1 at a clk edge set sector=0, targets and duty_r=PWM_INTERVAL, duty_g=0, duty_b=0, all counters 0, sector_done=0, and led outputs low.
REQ-024 SHALL have rst take priority over enable, and SHALL have the first step tick come TICK_INTERVAL cycles after rst deasserts with enable=1.
REQ-025 SHALL, when rst is asserted mid-sector, discard any pending step and sector_done pulse.

Structure
REQ-026 SHALL place the sector enum (S0..S5) and the default timing constants in a shared package, rgb_pkg.
REQ-027 SHALL place the PWM counter, the period-start duty commit and the three comparators in one sub-module, pwm_gen3, instantiated once.

Verification (TICK_INTERVAL=4, STEPS_PER_SECTOR=4, PWM_INTERVAL=8, STEP_VAL=2)
REQ-028 SHALL cover: rst held 3 cycles, then released with enable=1 -> duty=(8,0,0), sector=0, led_r high all period, first step tick 4 cycles after release.
REQ-029 SHALL cover: run 16 cycles -> G target steps 2,4,6,8, sector becomes 1, and sector_done is high exactly one cycle.
REQ-030 SHALL cover: run 96 cycles -> passes through sectors 1..5, wraps to 0, and targets return to (8,0,0).
REQ-031 SHALL cover: enable low for 20 cycles mid-sector -> targets and sector frozen, led PWM keeps toggling, and the next step tick comes at the remaining count.
REQ-032 SHALL cover: STEPS_PER_SECTOR=3 (STEP_VAL=2) -> G reaches 6 and is forced to 8 at the transition with no overflow.
REQ-033 SHALL cover: target changes mid-PWM-period -> duty_g and led_g change only at the next counter=0.

Source files
------------

// File: rtl/rgb_pkg.sv
// Shared definitions for the RGB hue sequencer: hue sector encoding and
// default timing constants (12 MHz clock, 1 ms step, 10 kHz PWM).
package rgb_pkg;

  // Six hue sectors; each one ramps exactly one channel up or down.
  typedef enum logic [2:0] {
    S0 = 3'd0,  // G rising
    S1 = 3'd1,  // R falling
    S2 = 3'd2,  // B rising
    S3 = 3'd3,  // G falling
    S4 = 3'd4,  // R rising
    S5 = 3'd5   // B falling
  } sector_t;

  localparam int TICK_INTERVAL_DEF    = 12000;
  localparam int STEPS_PER_SECTOR_DEF = 200;
  localparam int PWM_INTERVAL_DEF     = 1200;

  // Sector after s, wrapping S5 back to S0.
  function automatic sector_t next_sector(input sector_t s);
    return (s == S5) ? S0 : sector_t'(s + 3'd1);
  endfunction

endpackage

// File: rtl/pwm_gen3.sv
// Three-channel PWM generator: free-running period counter, duty commit
// at period start, and one comparator per channel.
module pwm_gen3 #(
  parameter int PWM_INTERVAL = 1200
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [$clog2(PWM_INTERVAL+1)-1:0]   target_r,
  input  logic [$clog2(PWM_INTERVAL+1)-1:0]   target_g,
  input  logic [$clog2(PWM_INTERVAL+1)-1:0]   target_b,
  output logic [$clog2(PWM_INTERVAL+1)-1:0]   duty_r,
  output logic [$clog2(PWM_INTERVAL+1)-1:0]   duty_g,
  output logic [$clog2(PWM_INTERVAL+1)-1:0]   duty_b,
  output logic                                led_r,
  output logic                                led_g,
  output logic                                led_b
);

  localparam int DW = $clog2(PWM_INTERVAL + 1);
  localparam logic [DW-1:0] FULL     = DW'(PWM_INTERVAL);
  localparam logic [DW-1:0] CNT_LAST = DW'(PWM_INTERVAL - 1);

  logic [DW-1:0] cnt;

  // Period counter runs regardless of enable; duties are loaded on the edge
  // that starts a new period so every cycle of that period sees one value.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      cnt    <= '0;
      duty_r <= FULL;
      duty_g <= '0;
      duty_b <= '0;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt    <= '0;
        duty_r <= target_r;
        duty_g <= target_g;
        duty_b <= target_b;
      end else begin
        cnt <= cnt + DW'(1);
      end
    end
  end

  // Comparators: duty 0 never drives high, full scale always drives high.
  // Outputs are held low while reset is asserted.
  assign led_r = !rst && (cnt < duty_r);
  assign led_g = !rst && (cnt < duty_g);
  assign led_b = !rst && (cnt < duty_b);

endmodule

// File: rtl/rgb_hue_sequencer.sv
// Hue-wheel sequencer: steps R/G/B targets around six sectors on a slow
// tick and feeds them to a three-channel PWM generator.
module rgb_hue_sequencer
  import rgb_pkg::*;
#(
  parameter int TICK_INTERVAL    = TICK_INTERVAL_DEF,
  parameter int STEPS_PER_SECTOR = STEPS_PER_SECTOR_DEF,
  parameter int PWM_INTERVAL     = PWM_INTERVAL_DEF,
  parameter int STEP_VAL         = PWM_INTERVAL / STEPS_PER_SECTOR
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  output logic [$clog2(PWM_INTERVAL+1)-1:0] duty_r,
  output logic [$clog2(PWM_INTERVAL+1)-1:0] duty_g,
  output logic [$clog2(PWM_INTERVAL+1)-1:0] duty_b,
  output logic                              led_r,
  output logic                              led_g,
  output logic                              led_b,
  output logic [2:0]                        sector,
  output logic                              sector_done
);

  localparam int DW = $clog2(PWM_INTERVAL + 1);
  localparam int TW = $clog2(TICK_INTERVAL + 1);
  localparam int SW = $clog2(STEPS_PER_SECTOR + 1);

  localparam logic [DW-1:0] FULL      = DW'(PWM_INTERVAL);
  localparam logic [DW:0]   FULL_X    = (DW+1)'(PWM_INTERVAL);
  localparam logic [DW:0]   STEP_X    = (DW+1)'(STEP_VAL);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_INTERVAL - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEPS_PER_SECTOR - 1);

  logic [TW-1:0] tick_cnt;
  logic [SW-1:0] step_cnt, step_cnt_n;
  sector_t       sector_q, sector_n;
  logic [DW-1:0] tgt_r, tgt_g, tgt_b;
  logic [DW-1:0] tgt_r_n, tgt_g_n, tgt_b_n;
  logic          step_tick;
  logic          last_step;
  logic          done_n;

  // Saturating ramp helpers, computed one bit wider so the sum cannot wrap.
  function automatic logic [DW-1:0] sat_up(input logic [DW-1:0] v);
    logic [DW:0] s;
    s = {1'b0, v} + STEP_X;
    return (s > FULL_X) ? FULL : s[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] sat_dn(input logic [DW-1:0] v);
    logic [DW:0] s;
    s = {1'b0, v} - STEP_X;
    return ({1'b0, v} < STEP_X) ? '0 : s[DW-1:0];
  endfunction

  // One-cycle step tick when the enabled tick counter is about to wrap.
  assign step_tick = enable && (tick_cnt == TICK_LAST);
  assign last_step = (step_cnt == STEP_LAST);

  // Next-state: apply the sector's ramp, then on the final step of a sector
  // snap the ramped channel to its endpoint and advance.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    sector_n   = sector_q;
    step_cnt_n = step_cnt;
    tgt_r_n    = tgt_r;
    tgt_g_n    = tgt_g;
    tgt_b_n    = tgt_b;
    done_n     = 1'b0;
    if (step_tick) begin
      unique case (sector_q)
        S0: tgt_g_n = last_step ? FULL : sat_up(tgt_g);
        S1: tgt_r_n = last_step ? '0   : sat_dn(tgt_r);
        S2: tgt_b_n = last_step ? FULL : sat_up(tgt_b);
        S3: tgt_g_n = last_step ? '0   : sat_dn(tgt_g);
        S4: tgt_r_n = last_step ? FULL : sat_up(tgt_r);
        S5: tgt_b_n = last_step ? '0   : sat_dn(tgt_b);
        default: ;
      endcase
      if (last_step) begin
        sector_n   = next_sector(sector_q);
        step_cnt_n = '0;
        done_n     = 1'b1;
      end else begin
        step_cnt_n = step_cnt + SW'(1);
      end
    end
  end

  // Sequencer state; everything except the PWM path freezes while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt    <= '0;
      step_cnt    <= '0;
      sector_q    <= S0;
      tgt_r       <= FULL;
      tgt_g       <= '0;
      tgt_b       <= '0;
      sector_done <= 1'b0;
    end else begin
      if (enable) begin
        tick_cnt <= step_tick ? '0 : tick_cnt + TW'(1);
      end
      step_cnt    <= step_cnt_n;
      sector_q    <= sector_n;
      tgt_r       <= tgt_r_n;
      tgt_g       <= tgt_g_n;
      tgt_b       <= tgt_b_n;
      sector_done <= done_n;
    end
  end

  assign sector = sector_q;

  pwm_gen3 #(
    .PWM_INTERVAL(PWM_INTERVAL)
  ) u_pwm (
    .clk      (clk),
    .rst      (rst),
    .target_r (tgt_r),
    .target_g (tgt_g),
    .target_b (tgt_b),
    .duty_r   (duty_r),
    .duty_g   (duty_g),
    .duty_b   (duty_b),
    .led_r    (led_r),
    .led_g    (led_g),
    .led_b    (led_b)
  );

endmodule

// File: tb/tb_rgb_hue_sequencer.sv
// Bench for rgb_hue_sequencer: two instances (4 and 3 steps per sector)
// compared every cycle against a closed-form hue-wheel model.
module tb_rgb_hue_sequencer;

  localparam int TI   = 4;
  localparam int P    = 8;
  localparam int STEP = 2;
  localparam int DW   = $clog2(P + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;

  logic [DW-1:0] duty_r [2];
  logic [DW-1:0] duty_g [2];
  logic [DW-1:0] duty_b [2];
  logic          led_r  [2];
  logic          led_g  [2];
  logic          led_b  [2];
  logic [2:0]    sector [2];
  logic          sector_done [2];

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  // Model state
  int sps [2] = '{4, 3};
  int m_tick;
  int m_phase;
  int m_n [2];
  int m_duty [2][3];
  bit m_done [2];
  int done_seen;

  always #5 clk = ~clk;

  rgb_hue_sequencer #(
    .TICK_INTERVAL(TI), .STEPS_PER_SECTOR(4), .PWM_INTERVAL(P), .STEP_VAL(STEP)
  ) dut0 (
    .clk(clk), .rst(rst), .enable(enable),
    .duty_r(duty_r[0]), .duty_g(duty_g[0]), .duty_b(duty_b[0]),
    .led_r(led_r[0]), .led_g(led_g[0]), .led_b(led_b[0]),
    .sector(sector[0]), .sector_done(sector_done[0])
  );

  rgb_hue_sequencer #(
    .TICK_INTERVAL(TI), .STEPS_PER_SECTOR(3), .PWM_INTERVAL(P), .STEP_VAL(STEP)
  ) dut1 (
    .clk(clk), .rst(rst), .enable(enable),
    .duty_r(duty_r[1]), .duty_g(duty_g[1]), .duty_b(duty_b[1]),
    .led_r(led_r[1]), .led_g(led_g[1]), .led_b(led_b[1]),
    .sector(sector[1]), .sector_done(sector_done[1])
  );

  // Target colour after n step ticks, from the hue-wheel definition.
  function automatic int target(input int n, input int s_per, input int ch);
    int s, k, up, dn;
    int v [3];
    s  = (n / s_per) % 6;
    k  = n % s_per;
    up = (k * STEP > P) ? P : k * STEP;
    dn = (P - k * STEP < 0) ? 0 : P - k * STEP;
    case (s)
      0:       v = '{P, up, 0};
      1:       v = '{dn, P, 0};
      2:       v = '{0, P, up};
      3:       v = '{0, dn, P};
      4:       v = '{up, 0, P};
      default: v = '{P, 0, dn};
    endcase
    return v[ch];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
  endtask

  // One clock with given rst/enable; update model, then compare all outputs.
  task automatic cycle(input bit r, input bit en);
    bit exp_tick;
    rst = r;
    enable = en;
    @(posedge clk);
    cyc++;
    if (r) begin
      m_tick = 0;
      m_phase = 0;
      for (int d = 0; d < 2; d++) begin
        m_n[d] = 0;
        m_done[d] = 1'b0;
        m_duty[d] = '{P, 0, 0};
      end
    end else begin
      if (m_phase == P - 1)
        for (int d = 0; d < 2; d++)
          for (int c = 0; c < 3; c++) m_duty[d][c] = target(m_n[d], sps[d], c);
      m_phase = (m_phase + 1) % P;
      for (int d = 0; d < 2; d++) m_done[d] = 1'b0;
      if (en) begin
        if (m_tick == TI - 1) begin
          m_tick = 0;
          for (int d = 0; d < 2; d++) begin
            if (m_n[d] % sps[d] == sps[d] - 1) m_done[d] = 1'b1;
            m_n[d]++;
          end
        end else begin
          m_tick++;
        end
      end
    end
    #1;
    exp_tick = en && !r && (m_tick == TI - 1);
    check("step_tick", dut0.step_tick, exp_tick);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("sector%0d", d), sector[d], (m_n[d] / sps[d]) % 6);
      check($sformatf("sector_done%0d", d), sector_done[d], m_done[d]);
      check($sformatf("duty_r%0d", d), duty_r[d], m_duty[d][0]);
      check($sformatf("duty_g%0d", d), duty_g[d], m_duty[d][1]);
      check($sformatf("duty_b%0d", d), duty_b[d], m_duty[d][2]);
      check($sformatf("led_r%0d", d), led_r[d], !r && (m_phase < m_duty[d][0]));
      check($sformatf("led_g%0d", d), led_g[d], !r && (m_phase < m_duty[d][1]));
      check($sformatf("led_b%0d", d), led_b[d], !r && (m_phase < m_duty[d][2]));
    end
    if (sector_done[0]) done_seen++;
  endtask

  initial begin
    // Reset held three cycles with enable already high.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);

    // First sector: four steps, one sector_done pulse.
    done_seen = 0;
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1);
    check("done_pulses_first_sector", done_seen, 1);
    check("sector_after_first", sector[0], 1);

    // Remaining sectors around the wheel back to S0.
    done_seen = 0;
    for (int i = 0; i < 80; i++) cycle(1'b0, 1'b1);
    check("done_pulses_wheel", done_seen, 5);
    check("sector_wrapped", sector[0], 0);

    // Freeze mid-sector for 20 cycles, then resume.
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0);
    for (int i = 0; i < 24; i++) cycle(1'b0, 1'b1);

    // Randomized enable with occasional mid-sector resets.
    for (int i = 0; i < 300; i++)
      cycle($urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0);

    // Deliberate reset just before a sector boundary, then a long run.
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 15; i++) cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 150; i++) cycle(1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
